// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between the core load/store port and dmem_responder
interface dmem_responder_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder (byte/half/word, sign/zero extend)
// Optional: define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module dmem_responder #(
  parameter int unsigned              ADDRESS_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH      = 32,
  parameter int unsigned              MEM_DEPTH_WORDS = 1024,
  parameter int unsigned              LATENCY         = 2,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam int unsigned IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDRESS_WIDTH:0] MEM_BYTES = (ADDRESS_WIDTH+1)'(4 * MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH_WORDS];

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_W-1:0]         word_idx;
  logic                     below_base;
  logic                     out_of_range;
  logic                     misalign;
  logic                     acc_err;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    store_word;
  logic [7:0]               lane_b;
  logic [15:0]              lane_h;

  // Decode works on the latched request so inputs may change freely after accept.
  assign offset       = addr_q - BASE_ADDR;
  assign below_base   = addr_q < BASE_ADDR;
  assign out_of_range = {1'b0, offset} >= MEM_BYTES;
  assign word_idx     = offset[IDX_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((size_q == 2'b01) && offset[0]) ||
                    ((size_q == 2'b10) && (offset[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = (size_q == 2'b11) || below_base || out_of_range || misalign;

  // Lane extraction and read-modify-write merge; misaligned low bits simply drop out.
  always_comb begin
    rd_word    = mem[word_idx];
    lane_b     = rd_word[7:0];
    lane_h     = offset[1] ? rd_word[31:16] : rd_word[15:0];
    store_word = rd_word;
    load_data  = rd_word;
    case (offset[1:0])
      2'b00:   lane_b = rd_word[7:0];
      2'b01:   lane_b = rd_word[15:8];
      2'b10:   lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    case (size_q)
      2'b00: begin
        load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
        case (offset[1:0])
          2'b00:   store_word[7:0]   = wdata_q[7:0];
          2'b01:   store_word[15:8]  = wdata_q[7:0];
          2'b10:   store_word[23:16] = wdata_q[7:0];
          default: store_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
        if (offset[1]) begin
          store_word[31:16] = wdata_q[15:0];
        end else begin
          store_word[15:0] = wdata_q[15:0];
        end
      end
      2'b10: begin
        load_data  = rd_word;
        store_word = wdata_q;
      end
      default: begin
        load_data  = '0;
        store_word = rd_word;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? '0 : load_data;
          mem_we  = we_q && !acc_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared; reset only blocks a write by forcing IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= store_word;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  dmem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_responder #(
    .ADDRESS_WIDTH  (32),
    .DATA_WIDTH     (32),
    .MEM_DEPTH_WORDS(1024),
    .LATENCY        (2),
    .BASE_ADDR      (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request from IDLE (called at posedge+1) and returns the response.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns,
                           output logic [31:0] rdata, output logic err, output int lat);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.rsp_ready    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout addr=%h rsp_valid=%b required 1", addr, bus.rsp_valid);
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks += 5;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
    if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    logic [31:0] rd; logic er; int lat;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'hDEAD_BEEF; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks += 2;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL wait_req_ready got %b want 0", bus.req_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b want 1", busy); end
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = bus.rsp_rdata; er = bus.rsp_err;
    checks += 3;
    if (lat !== 2) begin errors++; $display("FAIL latency got %0d want 2", lat); end
    if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got %h want 0", rd); end
    if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", er); end
    @(posedge clk); #1;
    do_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load got %h want deadbeef", rd); end
  endtask

  task automatic test_loads;
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb_0x13 got %h want ffffffde", rd); end
    do_access(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL lbu_0x13 got %h want 000000de", rd); end
    do_access(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_FFBE) begin errors++; $display("FAIL lb_0x11 got %h want ffffffbe", rd); end
    do_access(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_0x10 got %h want ffffbeef", rd); end
    do_access(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_DEAD) begin errors++; $display("FAIL lhu_0x12 got %h want 0000dead", rd); end
  endtask

  task automatic test_partial_stores;
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, 32'h12, 32'hFFFF_1234, 2'b01, 1'b0, rd, er, lat);
    do_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'h1234_BEEF) begin errors++; $display("FAIL sh_merge got %h want 1234beef", rd); end
    do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, er, lat);
    do_access(1'b1, 32'h11, 32'h0000_01AB, 2'b00, 1'b0, rd, er, lat);
    do_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_ABEF) begin errors++; $display("FAIL sb_merge got %h want deadabef", rd); end
    do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, er, lat);
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL oob_rdata got %h want 0", rd); end
    do_access(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL size11_err got %b want 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL size11_rdata got %h want 0", rd); end
    do_access(1'b1, 32'hFFC, 32'h5555_AAAA, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL last_word_err got %b want 0", er); end
    do_access(1'b1, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
    do_access(1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'h5555_AAAA) begin errors++; $display("FAIL last_word_load got %h want 5555aaaa", rd); end
    do_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_store_nowrite got %h want deadbeef", rd); end
  endtask

  task automatic test_hold;
    logic [31:0] rd; logic er; int lat;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h13;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b1; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    // garbage request held high outside IDLE must be ignored
    bus.req_we = 1'b1; bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.req_size = 2'b10;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    bus.req_valid = 1'b0;
    rd = bus.rsp_rdata; er = bus.rsp_err;
    checks++;
    if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL hold_rdata got %h want 000000de", rd); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd || bus.rsp_err !== er || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, rd, er);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", bus.req_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
    do_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ignored_store got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h0; bus.req_size = 2'b10; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bus.req_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.rsp_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midrst_nowrite got %h want deadbeef", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL misalign_word_err got %b want 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL misalign_word_rdata got %h want 0", rd); end
    do_access(1'b0, 32'h13, 32'h0, 2'b01, 1'b0, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL misalign_half_err got %b want 1", er); end
`else
    checks += 2;
    if (er !== 1'b0) begin errors++; $display("FAIL misalign_word_err got %b want 0", er); end
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_word_rdata got %h want deadbeef", rd); end
    do_access(1'b0, 32'h13, 32'h0, 2'b01, 1'b0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_DEAD) begin errors++; $display("FAIL misalign_half got %h want ffffdead", rd); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;
    test_reset();
    test_latency();
    test_loads();
    test_partial_stores();
    test_errors();
    test_hold();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
